lab3_mem_line_serializer: RTL and testbench
===========================================

# lab3_mem_line_serializer

Sits between the cache memory port and a 4-byte-wide memory. Takes one 16 B line request (refill read or evict write) and turns it into four in-order 4 B word transactions. It collects the four word responses into a single 16 B line response. Requests and responses overlap, so memory latency is pipelined across the four beats.

## Interface

Parameters:
- p_num_beats, 4, words per line; fixed at 4, and other values are unsupported.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high.
- linereq_msg  input  mem_req_16B_t  line request from the cache: type, opaque, addr, len, data.
- linereq_val  input  1  line request valid.
- linereq_rdy  output  1  line request ready.
- lineresp_msg  output  mem_resp_16B_t  line response to the cache.
- lineresp_val  output  1  line response valid.
- lineresp_rdy  input  1  line response ready.
- wordreq_msg  output  mem_req_4B_t  word request to memory.
- wordreq_val  output  1  word request valid.
- wordreq_rdy  input  1  word request ready.
- wordresp_msg  input  mem_resp_4B_t  word response from memory.
- wordresp_val  input  1  word response valid.
- wordresp_rdy  output  1  word response ready.

## Operation

- **States:** IDLE, BUSY, RESP.
- **Registers:** line request (type, opaque, line base addr = addr & ~0xF, 128 b data); req_cnt (3 b); resp_cnt (3 b); 128 b assembly buffer.
- **IDLE:**
  - linereq_rdy = 1.
  - On linereq_val, latch the request, clear both counters and the buffer, and go to BUSY.
  - The len field is ignored; every request is treated as a full line.
- **BUSY, issue side:**
  - wordreq_val = (req_cnt < 4).
  - wordreq_msg: type = latched type (INIT is forwarded as WRITE); opaque = {6'b0, req_cnt[1:0]}; addr = base + 4·req_cnt; len = 0 (full word).
  - Write data = data[32·req_cnt +: 32]; read data = 0.
  - req_cnt increments on each wordreq_val & wordreq_rdy.
- **BUSY, collect side:**
  - wordresp_rdy = (resp_cnt < req_cnt).
  - On wordresp_val & wordresp_rdy: for a READ, buffer[32·resp_cnt +: 32] = wordresp data; resp_cnt then increments.
  - Memory returns responses in order. The response opaque and type are not checked.
- **BUSY exit:** when resp_cnt reaches 4, go to RESP.
- **RESP:**
  - lineresp_val = 1.
  - lineresp_msg: type = latched type; opaque = latched opaque; test = 0; len = 0; data = buffer (all zeros for WRITE/INIT).
  - On lineresp_rdy, return to IDLE.
- **Single transaction:** only one line is in flight. linereq_rdy = 0 in BUSY and RESP.
- **Same-cycle events:** a word request fire and a word response fire in the same cycle are both honoured.

## Timing

- **Reset values** (asynchronous, take effect immediately):
  - State = IDLE; counters and buffer = 0.
  - linereq_rdy = 1 once reset deasserts (0 while reset is high).
  - lineresp_val = 0; wordreq_val = 0; wordresp_rdy = 0.
- **Reset mid-transaction:** the transaction is aborted. No line response is produced, and late word responses after reset are not consumed until a new line is in flight.
- **Issue rate:** request accepted at cycle 0 → first word request valid at cycle 1. With wordreq_rdy held high, beats issue at cycles 1–4.
- **Line response:** lineresp_val rises the cycle after the 4th word response is accepted. With 1-cycle memory, word responses arrive at cycles 2–5 and lineresp_val is high at cycle 6.
- **Back-to-back lines:** the earliest next accept is the cycle after lineresp fires, i.e. one IDLE cycle between lines.
- **Output stability:** all outputs are decoded from registered state. wordreq_msg and lineresp_msg stay stable while their val is high and rdy is low.
- **Counter width:** counters saturate at 4 and never wrap.

## Test plan

- **Read refill, 1-cycle memory:**
  - Stimulus: READ at addr 0x00001234, opaque 0x5A; memory holds 0x11111111, 0x22222222, 0x33333333, 0x44444444 at 0x1230–0x123C.
  - Response: word reads at 0x1230, 0x1234, 0x1238, 0x123C in cycles 1–4; lineresp at cycle 6 with data 0x44444444_33333333_22222222_11111111 and opaque 0x5A.
- **Evict write:**
  - Stimulus: WRITE at 0x00002000 with data 0xDDDD…_CCCC…_BBBB…_AAAA….
  - Response: four writes carrying 0xAAAAAAAA to 0x2000 … 0xDDDDDDDD to 0x200C; lineresp type WRITE with data 0.
- **Memory backpressure:**
  - Stimulus: wordreq_rdy toggles 0/1 with random response delays of 0–5 cycles.
  - Response: addresses stay in order, msg is stable while stalled, the line data is correct, and exactly four beats are issued.
- **Line response stall:**
  - Stimulus: lineresp_rdy = 0 for 5 cycles.
  - Response: lineresp_val stays 1 with constant msg, linereq_rdy stays 0, and no extra word requests are issued.
- **Reset mid-BUSY:**
  - Stimulus: assert reset after 2 beats have issued.
  - Response: outputs go immediately to their reset values; a following READ completes correctly with fresh data.
- **Back-to-back reads:**
  - Stimulus: two lines at 0x0 and 0x10.
  - Response: second linereq accepted exactly one cycle after the first lineresp fires, and both lines return correct data.

Source files
------------

// File: rtl/lab3_mem_line_serializer.sv
// lab3_mem_line_serializer
// Turns one 16 B cache line request into four in-order 4 B word transactions,
// then gathers the four word responses into a single 16 B line response.
// Word requests and word responses overlap, so memory latency is pipelined
// across the beats. Only one line is in flight at a time.
//
// Message layouts (flat vectors, MSB first):
//   line request  [174:0] : type[3] opaque[8] addr[32] len[4] data[128]
//   line response [144:0] : type[3] opaque[8] test[2] len[4] data[128]
//   word request  [76:0]  : type[3] opaque[8] addr[32] len[2] data[32]
//   word response [46:0]  : type[3] opaque[8] test[2] len[2] data[32]
// Type encoding: READ = 0, WRITE = 1, INIT = 2.

module lab3_mem_line_serializer #(
  parameter int p_num_beats = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [174:0] linereq_msg,
  input  logic         linereq_val,
  output logic         linereq_rdy,
  output logic [144:0] lineresp_msg,
  output logic         lineresp_val,
  input  logic         lineresp_rdy,
  output logic [76:0]  wordreq_msg,
  output logic         wordreq_val,
  input  logic         wordreq_rdy,
  input  logic [46:0]  wordresp_msg,
  input  logic         wordresp_val,
  output logic         wordresp_rdy
);

  localparam logic [2:0] TypeRead  = 3'd0;
  localparam logic [2:0] TypeWrite = 3'd1;
  localparam logic [2:0] TypeInit  = 3'd2;
  localparam logic [2:0] NumBeats  = 3'(p_num_beats);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t         state_q,     state_d;
  logic [2:0]     reqType_q,   reqType_d;
  logic [7:0]     reqOpaque_q, reqOpaque_d;
  logic [27:0]    reqBase_q,   reqBase_d;
  logic [127:0]   reqData_q,   reqData_d;
  logic [2:0]     reqCnt_q,    reqCnt_d;
  logic [2:0]     respCnt_q,   respCnt_d;
  logic [127:0]   buffer_q,    buffer_d;

  logic [2:0]     wordType;
  logic [31:0]    wordData;

  // The request length, the low address bits and the word response header
  // carry no information here: every line is aligned and full, and memory
  // answers in order.
  logic unusedBits;
  assign unusedBits = ^{linereq_msg[135:128], wordresp_msg[46:32]};

  // State register; reset aborts any line in flight and clears all counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      reqType_q   <= '0;
      reqOpaque_q <= '0;
      reqBase_q   <= '0;
      reqData_q   <= '0;
      reqCnt_q    <= '0;
      respCnt_q   <= '0;
      buffer_q    <= '0;
    end else begin
      state_q     <= state_d;
      reqType_q   <= reqType_d;
      reqOpaque_q <= reqOpaque_d;
      reqBase_q   <= reqBase_d;
      reqData_q   <= reqData_d;
      reqCnt_q    <= reqCnt_d;
      respCnt_q   <= respCnt_d;
      buffer_q    <= buffer_d;
    end
  end

  // Next-state and output decode; every output depends only on registered
  // state (and reset), so messages hold steady while their handshake stalls.
  always_comb begin
    state_d     = state_q;
    reqType_d   = reqType_q;
    reqOpaque_d = reqOpaque_q;
    reqBase_d   = reqBase_q;
    reqData_d   = reqData_q;
    reqCnt_d    = reqCnt_q;
    respCnt_d   = respCnt_q;
    buffer_d    = buffer_q;

    linereq_rdy  = 1'b0;
    lineresp_val = 1'b0;
    wordreq_val  = 1'b0;
    wordresp_rdy = 1'b0;

    wordType = (reqType_q == TypeInit) ? TypeWrite : reqType_q;
    wordData = (wordType == TypeWrite) ? reqData_q[32*reqCnt_q[1:0] +: 32] : 32'h0;

    wordreq_msg  = {wordType, 6'b0, reqCnt_q[1:0], reqBase_q, reqCnt_q[1:0], 2'b00,
                    2'b00, wordData};
    lineresp_msg = {reqType_q, reqOpaque_q, 2'b00, 4'b0000, buffer_q};

    case (state_q)
      IDLE: begin
        linereq_rdy = ~reset;
        if (linereq_val) begin
          reqType_d   = linereq_msg[174:172];
          reqOpaque_d = linereq_msg[171:164];
          reqBase_d   = linereq_msg[163:136];
          reqData_d   = linereq_msg[127:0];
          reqCnt_d    = '0;
          respCnt_d   = '0;
          buffer_d    = '0;
          state_d     = BUSY;
        end
      end

      BUSY: begin
        wordreq_val  = (reqCnt_q < NumBeats);
        wordresp_rdy = (respCnt_q < reqCnt_q);
        if (wordreq_val && wordreq_rdy) begin
          reqCnt_d = reqCnt_q + 3'd1;
        end
        if (wordresp_rdy && wordresp_val) begin
          if (reqType_q == TypeRead) begin
            buffer_d[32*respCnt_q[1:0] +: 32] = wordresp_msg[31:0];
          end
          respCnt_d = respCnt_q + 3'd1;
          if (respCnt_q == NumBeats - 3'd1) begin
            state_d = RESP;
          end
        end
      end

      RESP: begin
        lineresp_val = 1'b1;
        if (lineresp_rdy) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_lab3_mem_line_serializer.sv
// tb_lab3_mem_line_serializer
// Table-driven bench: each row is one line transaction run against a small
// in-order word memory with optional backpressure and response delay,
// followed by hand-written reset-mid-line and back-to-back sequences.

module tb_lab3_mem_line_serializer;

  localparam logic [2:0] T_READ  = 3'd0;
  localparam logic [2:0] T_WRITE = 3'd1;
  localparam logic [2:0] T_INIT  = 3'd2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [174:0] linereq_msg = '0;
  logic         linereq_val = 1'b0;
  logic         linereq_rdy;
  logic [144:0] lineresp_msg;
  logic         lineresp_val;
  logic         lineresp_rdy = 1'b0;
  logic [76:0]  wordreq_msg;
  logic         wordreq_val;
  logic         wordreq_rdy = 1'b0;
  logic [46:0]  wordresp_msg = '0;
  logic         wordresp_val = 1'b0;
  logic         wordresp_rdy;

  lab3_mem_line_serializer #(.p_num_beats(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .linereq_msg  (linereq_msg),
    .linereq_val  (linereq_val),
    .linereq_rdy  (linereq_rdy),
    .lineresp_msg (lineresp_msg),
    .lineresp_val (lineresp_val),
    .lineresp_rdy (lineresp_rdy),
    .wordreq_msg  (wordreq_msg),
    .wordreq_val  (wordreq_val),
    .wordreq_rdy  (wordreq_rdy),
    .wordresp_msg (wordresp_msg),
    .wordresp_val (wordresp_val),
    .wordresp_rdy (wordresp_rdy)
  );

  // Free-running clock and cycle counter
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int testsRun = 0;
  int failCount = 0;

  logic [31:0] mem [logic [31:0]];

  int          resBeats;
  logic [31:0] resAddr [4];
  logic [31:0] resData [4];
  logic [2:0]  resType [4];
  logic [7:0]  resOpq  [4];
  logic [144:0] resLine;
  int          acceptCyc, firstReqCyc, respValCyc, respFireCyc;
  bit          resRdySeen, resStallBad, resExtraReq, resTimeout, resQueueLeft;

  typedef struct {
    logic [2:0]   t;
    logic [7:0]   op;
    logic [31:0]  addr;
    logic [127:0] data;
    int           maxDelay;
    bit           toggle;
    int           lineStall;
    bit           chkTiming;
    logic [2:0]   expWordType;
    logic [31:0]  expAddr0;
    logic [127:0] expBeatData;
    logic [127:0] expLine;
  } vec_t;

  vec_t vecs [6];

  task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Runs one line transaction: presents the request, plays memory, and
  // captures every word beat and the final line response.
  task automatic applyStimulus(input logic [2:0] t, input logic [7:0] op, input logic [31:0] addr,
                               input logic [127:0] data, input int maxDelay, input bit toggle,
                               input int lineStall);
    logic [31:0]  qData [$];
    int           qDue [$];
    int           lastDue;
    int           due;
    int           dly;
    int           stallCnt;
    bit           done;
    bit           prevStalled;
    bit           lineSeen;
    logic [76:0]  prevMsg;
    logic [144:0] firstLine;
    logic [31:0]  a;

    resBeats = 0; resRdySeen = 0; resStallBad = 0; resExtraReq = 0;
    resTimeout = 0; resQueueLeft = 0; resLine = '0;
    firstReqCyc = -1; respValCyc = -1; respFireCyc = -1;
    lastDue = 0; stallCnt = 0; done = 0; prevStalled = 0; lineSeen = 0;
    prevMsg = '0; firstLine = '0;

    checkOutput("linereq_rdy when idle", {159'b0, linereq_rdy}, 160'd1);
    linereq_msg = {t, op, addr, 4'hF, data};
    linereq_val = 1'b1;
    acceptCyc = cyc;
    @(posedge clk); #1;
    linereq_val = 1'b0;
    linereq_msg = '0;

    for (int k = 0; k < 300 && !done; k++) begin
      wordreq_rdy = toggle ? ((cyc % 2) == 1) : 1'b1;
      if (prevStalled && (!wordreq_val || wordreq_msg !== prevMsg)) resStallBad = 1;
      prevStalled = wordreq_val && !wordreq_rdy;
      prevMsg = wordreq_msg;
      if (wordreq_val && firstReqCyc < 0) firstReqCyc = cyc;
      if (linereq_rdy) resRdySeen = 1;
      if (wordreq_val && resBeats >= 4) resExtraReq = 1;

      if (wordreq_val && wordreq_rdy) begin
        a = wordreq_msg[65:34];
        if (resBeats < 4) begin
          resAddr[resBeats] = a;
          resData[resBeats] = wordreq_msg[31:0];
          resType[resBeats] = wordreq_msg[76:74];
          resOpq[resBeats]  = wordreq_msg[73:66];
        end
        resBeats++;
        if (wordreq_msg[76:74] == T_WRITE) mem[a] = wordreq_msg[31:0];
        dly = (maxDelay > 0) ? int'($urandom_range(maxDelay, 0)) : 0;
        due = cyc + 1 + dly;
        if (due < lastDue) due = lastDue;
        lastDue = due;
        if (wordreq_msg[76:74] == T_READ)
          qData.push_back(mem.exists(a) ? mem[a] : 32'h0);
        else
          qData.push_back(32'h0);
        qDue.push_back(due);
      end

      if (qDue.size() > 0 && qDue[0] <= cyc) begin
        wordresp_val = 1'b1;
        wordresp_msg = {3'd0, 8'hEE, 2'b00, 2'b00, qData[0]};
      end else begin
        wordresp_val = 1'b0;
        wordresp_msg = {3'd0, 8'h00, 4'b0000, 32'hDEADBEEF};
      end
      if (wordresp_val && wordresp_rdy) begin
        void'(qData.pop_front());
        void'(qDue.pop_front());
      end

      lineresp_rdy = 1'b0;
      if (lineresp_val) begin
        if (!lineSeen) begin
          lineSeen = 1;
          respValCyc = cyc;
          firstLine = lineresp_msg;
        end else if (lineresp_msg !== firstLine) begin
          resStallBad = 1;
        end
        if (stallCnt < lineStall) begin
          stallCnt++;
        end else begin
          lineresp_rdy = 1'b1;
          resLine = lineresp_msg;
          respFireCyc = cyc;
          done = 1;
        end
      end
      @(posedge clk); #1;
    end

    resTimeout = !done;
    resQueueLeft = (qDue.size() != 0);
    lineresp_rdy = 1'b0;
    wordresp_val = 1'b0;
    wordreq_rdy = 1'b0;
  endtask

  // Compares everything captured by the last applyStimulus call
  task automatic checkLine(input string tag, input logic [2:0] t, input logic [7:0] op,
                           input logic [2:0] expWT, input logic [31:0] expAddr0,
                           input logic [127:0] expBeat, input logic [127:0] expLine);
    checkOutput({tag, " timeout"}, {159'b0, resTimeout}, 160'd0);
    checkOutput({tag, " beat count"}, 160'(resBeats), 160'd4);
    for (int j = 0; j < 4; j++) begin
      checkOutput($sformatf("%s beat%0d addr", tag, j), 160'(resAddr[j]), 160'(expAddr0 + 32'(4 * j)));
      checkOutput($sformatf("%s beat%0d data", tag, j), 160'(resData[j]), 160'(expBeat[32*j +: 32]));
      checkOutput($sformatf("%s beat%0d type", tag, j), 160'(resType[j]), 160'(expWT));
      checkOutput($sformatf("%s beat%0d opaque", tag, j), 160'(resOpq[j]), 160'(j));
    end
    checkOutput({tag, " line type"}, 160'(resLine[144:142]), 160'(t));
    checkOutput({tag, " line opaque"}, 160'(resLine[141:134]), 160'(op));
    checkOutput({tag, " line test/len"}, 160'(resLine[133:128]), 160'd0);
    checkOutput({tag, " line data"}, 160'(resLine[127:0]), 160'(expLine));
    checkOutput({tag, " linereq_rdy busy"}, {159'b0, resRdySeen}, 160'd0);
    checkOutput({tag, " stall stability"}, {159'b0, resStallBad}, 160'd0);
    checkOutput({tag, " extra word req"}, {159'b0, resExtraReq}, 160'd0);
    checkOutput({tag, " responses drained"}, {159'b0, resQueueLeft}, 160'd0);
  endtask

  // Safety net in case the design wedges outside any bounded wait
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int fired;
    int r1;

    mem[32'h1230] = 32'h11111111; mem[32'h1234] = 32'h22222222;
    mem[32'h1238] = 32'h33333333; mem[32'h123C] = 32'h44444444;
    mem[32'h0000] = 32'h10101010; mem[32'h0004] = 32'h20202020;
    mem[32'h0008] = 32'h30303030; mem[32'h000C] = 32'h40404040;
    mem[32'h0010] = 32'h50505050; mem[32'h0014] = 32'h60606060;
    mem[32'h0018] = 32'h70707070; mem[32'h001C] = 32'h80808080;

    vecs[0] = '{T_READ,  8'h5A, 32'h00001234, 128'h0, 0, 1'b0, 0, 1'b1,
                T_READ,  32'h1230, 128'h0,
                128'h44444444_33333333_22222222_11111111};
    vecs[1] = '{T_WRITE, 8'h21, 32'h00002000, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA,
                0, 1'b0, 0, 1'b1,
                T_WRITE, 32'h2000, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 128'h0};
    vecs[2] = '{T_READ,  8'h33, 32'h00002008, 128'h0, 0, 1'b0, 5, 1'b1,
                T_READ,  32'h2000, 128'h0,
                128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA};
    vecs[3] = '{T_READ,  8'hC4, 32'h0000123C, 128'h0, 5, 1'b1, 0, 1'b0,
                T_READ,  32'h1230, 128'h0,
                128'h44444444_33333333_22222222_11111111};
    vecs[4] = '{T_INIT,  8'h7E, 32'h00003004, 128'h0F0E0D0C_0B0A0908_07060504_03020100,
                3, 1'b1, 2, 1'b0,
                T_WRITE, 32'h3000, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 128'h0};
    vecs[5] = '{T_READ,  8'h99, 32'h0000300F, 128'h0, 2, 1'b0, 1, 1'b0,
                T_READ,  32'h3000, 128'h0,
                128'h0F0E0D0C_0B0A0908_07060504_03020100};

    // Reset state, observed while reset is still asserted
    #3;
    checkOutput("reset linereq_rdy", {159'b0, linereq_rdy}, 160'd0);
    checkOutput("reset wordreq_val", {159'b0, wordreq_val}, 160'd0);
    checkOutput("reset wordresp_rdy", {159'b0, wordresp_rdy}, 160'd0);
    checkOutput("reset lineresp_val", {159'b0, lineresp_val}, 160'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1 checkOutput("post-reset linereq_rdy", {159'b0, linereq_rdy}, 160'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].t, vecs[i].op, vecs[i].addr, vecs[i].data,
                    vecs[i].maxDelay, vecs[i].toggle, vecs[i].lineStall);
      checkLine($sformatf("row%0d", i), vecs[i].t, vecs[i].op, vecs[i].expWordType,
                vecs[i].expAddr0, vecs[i].expBeatData, vecs[i].expLine);
      if (vecs[i].chkTiming) begin
        checkOutput($sformatf("row%0d first wordreq cycle", i), 160'(firstReqCyc - acceptCyc), 160'd1);
        checkOutput($sformatf("row%0d lineresp cycle", i), 160'(respValCyc - acceptCyc), 160'd6);
      end
    end

    // Reset after two beats have issued; outputs must drop immediately
    checkOutput("abort linereq_rdy idle", {159'b0, linereq_rdy}, 160'd1);
    linereq_msg = {T_READ, 8'h11, 32'h00000008, 4'h0, 128'h0};
    linereq_val = 1'b1;
    @(posedge clk); #1;
    linereq_val = 1'b0;
    linereq_msg = '0;
    wordreq_rdy = 1'b1;
    fired = 0;
    for (int k = 0; k < 10 && fired < 2; k++) begin
      if (wordreq_val) fired++;
      @(posedge clk); #1;
    end
    checkOutput("abort beats before reset", 160'(fired), 160'd2);
    wordreq_rdy = 1'b0;
    #2 reset = 1'b1;
    #1;
    checkOutput("abort linereq_rdy", {159'b0, linereq_rdy}, 160'd0);
    checkOutput("abort wordreq_val", {159'b0, wordreq_val}, 160'd0);
    checkOutput("abort wordresp_rdy", {159'b0, wordresp_rdy}, 160'd0);
    checkOutput("abort lineresp_val", {159'b0, lineresp_val}, 160'd0);
    @(posedge clk); @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checkOutput("abort release linereq_rdy", {159'b0, linereq_rdy}, 160'd1);
    checkOutput("abort release wordreq_val", {159'b0, wordreq_val}, 160'd0);
    wordresp_val = 1'b1;
    wordresp_msg = {3'd0, 8'h01, 4'b0000, 32'hBAD0BAD0};
    @(posedge clk); #1;
    checkOutput("late resp not consumed", {159'b0, wordresp_rdy}, 160'd0);
    checkOutput("late resp stays idle", {159'b0, linereq_rdy}, 160'd1);
    wordresp_val = 1'b0;
    wordresp_msg = '0;
    applyStimulus(T_READ, 8'h12, 32'h00000004, 128'h0, 0, 1'b0, 0);
    checkLine("after abort", T_READ, 8'h12, T_READ, 32'h0, 128'h0,
              128'h40404040_30303030_20202020_10101010);

    // Back-to-back lines with one idle cycle between them
    applyStimulus(T_READ, 8'h01, 32'h00000000, 128'h0, 0, 1'b0, 0);
    checkLine("b2b first", T_READ, 8'h01, T_READ, 32'h0, 128'h0,
              128'h40404040_30303030_20202020_10101010);
    r1 = respFireCyc;
    applyStimulus(T_READ, 8'h02, 32'h00000010, 128'h0, 0, 1'b0, 0);
    checkOutput("b2b accept gap", 160'(acceptCyc - r1), 160'd1);
    checkLine("b2b second", T_READ, 8'h02, T_READ, 32'h10, 128'h0,
              128'h80808080_70707070_60606060_50505050);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
